// File: rtl/bnn_ocr_pkg.sv
// Shared types and constants for the BNN OCR image path.
// The loader FSM state encoding and the image/command constants live here.
package bnn_ocr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RECV,
      ST_WAIT_FULL,
      ST_READY
   } loader_state_t;

   localparam int          IMG_BYTES  = 113;
   localparam logic [7:0]  CMD_LOAD   = 8'hA5;
   localparam logic [7:0]  CMD_CLEAR  = 8'h5A;
   localparam int          CNT_W      = 7;
   localparam logic [1:0]  FULL_WAIT_LAST = 2'd3;

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags expiry once the count reaches TIMEOUT_CYCLES-1.
module idle_timer #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] cnt_q;

   assign expired = en && (cnt_q == W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/image_loader_ctrl.sv
// Receives a command byte plus IMG_BYTES payload bytes from the serial front
// end, writes them to the image store and hands the image to the classifier.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  IDLE       | waiting for a command byte
//  CLEAR      | one-cycle store reset, byte count zeroed
//  RECV       | forwarding payload bytes, idle timeout armed
//  WAIT_FULL  | last byte written, waiting up to 4 cycles for buffer_full
//  READY      | image held for the classifier until inference_done
module image_loader_ctrl
   import bnn_ocr_pkg::*;
#(
   parameter int         IMG_BYTES      = bnn_ocr_pkg::IMG_BYTES,
   parameter int         TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0] CMD_LOAD       = bnn_ocr_pkg::CMD_LOAD,
   parameter logic [7:0] CMD_CLEAR      = bnn_ocr_pkg::CMD_CLEAR
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       write_ready,
   input  logic       buffer_full,
   input  logic       inference_done,
   output logic       clear_buffer,
   output logic [7:0] data_out,
   output logic       write_request,
   output logic       img_ready,
   output logic       busy,
   output logic       error
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_BYTES - 1);

   loader_state_t    state_q;
   logic [CNT_W-1:0] byte_cnt_q;
   logic [1:0]       wait_cnt_q;
   logic [7:0]       data_out_q;
   logic             write_request_q;
   logic             clear_buffer_q;
   logic             img_ready_q;
   logic             error_q;
   logic             tmr_expired;

   // The timer only runs in RECV; any received byte restarts it, so a byte
   // arriving in the expiry cycle wins.
   idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     ((state_q != ST_RECV) || rx_valid),
      .en      (state_q == ST_RECV),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         byte_cnt_q      <= '0;
         wait_cnt_q      <= '0;
         data_out_q      <= 8'h00;
         write_request_q <= 1'b0;
         clear_buffer_q  <= 1'b0;
         img_ready_q     <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         write_request_q <= 1'b0;
         clear_buffer_q  <= 1'b0;
         error_q         <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rx_valid) begin
                  if (rx_data == CMD_LOAD) begin
                     clear_buffer_q <= 1'b1;
                     state_q        <= ST_CLEAR;
                  end else if (rx_data == CMD_CLEAR) begin
                     clear_buffer_q <= 1'b1;
                  end else begin
                     error_q <= 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               byte_cnt_q <= '0;
               wait_cnt_q <= '0;
               state_q    <= ST_RECV;
            end
            ST_RECV: begin
               if (rx_valid) begin
                  if (write_ready) begin
                     data_out_q      <= rx_data;
                     write_request_q <= 1'b1;
                     byte_cnt_q      <= byte_cnt_q + 1'b1;
                     if (byte_cnt_q == LAST_IDX) begin
                        wait_cnt_q <= '0;
                        state_q    <= ST_WAIT_FULL;
                     end
                  end else begin
                     error_q <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end else if (tmr_expired) begin
                  error_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT_FULL: begin
               if (buffer_full) begin
                  img_ready_q <= 1'b1;
                  state_q     <= ST_READY;
               end else if (wait_cnt_q == FULL_WAIT_LAST) begin
                  error_q <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            ST_READY: begin
               if (rx_valid) begin
                  error_q <= 1'b1;
               end
               if (inference_done) begin
                  img_ready_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign clear_buffer  = clear_buffer_q;
   assign data_out      = data_out_q;
   assign write_request = write_request_q;
   assign img_ready     = img_ready_q;
   assign busy          = (state_q != ST_IDLE);
   assign error         = error_q;

endmodule

// File: tb/tb_image_loader_ctrl.sv
// Scenario bench for image_loader_ctrl with a behavioural image-store model
// and randomized payloads and inter-byte gaps.
module tb_image_loader_ctrl;

   localparam int IMG = 113;
   localparam int TMO = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       write_ready = 1'b1;
   logic       buffer_full = 1'b0;
   logic       inference_done = 1'b0;
   logic       clear_buffer;
   logic [7:0] data_out;
   logic       write_request;
   logic       img_ready;
   logic       busy;
   logic       error;

   int checks = 0;
   int errors = 0;

   // store model and activity monitor state
   int         st_cnt = 0;
   bit         bf_block = 1'b0;
   int         n_clr = 0, n_err = 0, busy_seen = 0, early_rdy = 0, both_hi = 0;
   logic [7:0] wr_q[$];
   logic [7:0] payload[IMG];
   int         gap_max = 3;

   image_loader_ctrl #(
      .IMG_BYTES      (IMG),
      .TIMEOUT_CYCLES (TMO),
      .CMD_LOAD       (8'hA5),
      .CMD_CLEAR      (8'h5A)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .write_ready    (write_ready),
      .buffer_full    (buffer_full),
      .inference_done (inference_done),
      .clear_buffer   (clear_buffer),
      .data_out       (data_out),
      .write_request  (write_request),
      .img_ready      (img_ready),
      .busy           (busy),
      .error          (error)
   );

   always #5 clk = ~clk;

   // Store holds written bytes; buffer_full follows the count one cycle late.
   always @(negedge clk) begin
      bit nb;
      if (clear_buffer) n_clr++;
      if (error) n_err++;
      if (busy) busy_seen++;
      if (write_request && clear_buffer) both_hi++;
      if (img_ready && !buffer_full) early_rdy++;
      nb = !clear_buffer && (st_cnt == IMG) && !bf_block;
      if (clear_buffer) st_cnt = 0;
      else if (write_request) begin
         st_cnt++;
         wr_q.push_back(data_out);
      end
      buffer_full = nb;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic mon_clear();
      n_clr = 0; n_err = 0; busy_seen = 0; early_rdy = 0;
      wr_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      tick(gap);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < IMG; i++) payload[i] = 8'($urandom);
   endtask

   task automatic send_payload(input int n);
      send_byte(8'hA5, 1);
      for (int i = 0; i < n; i++) send_byte(payload[i], $urandom_range(0, gap_max));
   endtask

   // Sends a full image and checks the store contents and the handshake.
   task automatic run_full_image(input string name);
      int t, bad;
      mon_clear();
      send_payload(IMG);
      t = 0;
      while (!img_ready && t < 30) begin
         tick(1);
         t++;
      end
      checks++;
      if (!img_ready) begin
         errors++;
         $display("FAIL %s ready_timeout: img_ready=%0b after %0d cycles, expected 1", name, img_ready, t);
      end
      chk({name, " clear_pulses"}, n_clr, 1);
      chk({name, " write_count"}, wr_q.size(), IMG);
      bad = 0;
      for (int i = 0; i < IMG && i < wr_q.size(); i++)
         if (wr_q[i] !== payload[i]) begin
            if (bad == 0)
               $display("FAIL %s data[%0d]: got %02h expected %02h", name, i, wr_q[i], payload[i]);
            bad++;
         end
      checks++;
      if (bad != 0) errors++;
      chk({name, " ready_before_full"}, early_rdy, 0);
      chk({name, " errors"}, n_err, 0);
      tick($urandom_range(1, 6));
      chk({name, " img_ready_held"}, img_ready, 1);
      chk({name, " busy_in_ready"}, busy, 1);
      inference_done = 1'b1;
      tick(1);
      inference_done = 1'b0;
      chk({name, " img_ready_after_done"}, img_ready, 0);
      chk({name, " busy_after_done"}, busy, 0);
      tick(2);
   endtask

   task automatic test_reset();
      tick(3);
      chk("rst clear_buffer", clear_buffer, 0);
      chk("rst data_out", data_out, 0);
      chk("rst write_request", write_request, 0);
      chk("rst img_ready", img_ready, 0);
      chk("rst busy", busy, 0);
      chk("rst error", error, 0);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_counting_image();
      for (int i = 0; i < IMG; i++) payload[i] = 8'(i);
      run_full_image("count_img");
   endtask

   task automatic test_rx_in_ready();
      int e0;
      fill_random();
      mon_clear();
      send_payload(IMG);
      tick(6);
      chk("ready_rx img_ready", img_ready, 1);
      e0 = n_err;
      send_byte(8'h3C, 2);
      chk("ready_rx error", n_err - e0, 1);
      chk("ready_rx img_ready_kept", img_ready, 1);
      chk("ready_rx writes", wr_q.size(), IMG);
      inference_done = 1'b1;
      tick(1);
      inference_done = 1'b0;
      tick(2);
   endtask

   task automatic test_back_to_back();
      fill_random();
      gap_max = 0;
      run_full_image("b2b_img");
      gap_max = 3;
   endtask

   task automatic test_clear_cmd();
      mon_clear();
      send_byte(8'h5A, 4);
      chk("clr_cmd clear_pulses", n_clr, 1);
      chk("clr_cmd busy_seen", busy_seen, 0);
      chk("clr_cmd writes", wr_q.size(), 0);
      chk("clr_cmd errors", n_err, 0);
   endtask

   task automatic test_bad_cmd();
      mon_clear();
      send_byte(8'h3C, 4);
      chk("bad_cmd errors", n_err, 1);
      chk("bad_cmd clears", n_clr, 0);
      chk("bad_cmd writes", wr_q.size(), 0);
      chk("bad_cmd busy_seen", busy_seen, 0);
   endtask

   task automatic test_timeout();
      int first;
      fill_random();
      mon_clear();
      send_payload(49);
      send_byte(payload[49], 0);
      first = -1;
      for (int i = 1; i <= TMO + 20; i++) begin
         tick(1);
         if (error && first < 0) first = i;
      end
      chk("timeout error_cycle", first, TMO);
      chk("timeout errors", n_err, 1);
      chk("timeout writes", wr_q.size(), 50);
      chk("timeout busy", busy, 0);
      chk("timeout img_ready", img_ready, 0);
   endtask

   task automatic test_overflow();
      fill_random();
      mon_clear();
      send_payload(10);
      write_ready = 1'b0;
      send_byte(payload[10], 3);
      write_ready = 1'b1;
      chk("ovf errors", n_err, 1);
      chk("ovf writes", wr_q.size(), 10);
      chk("ovf busy", busy, 0);
   endtask

   task automatic test_wait_full_timeout();
      fill_random();
      mon_clear();
      bf_block = 1'b1;
      send_payload(IMG);
      tick(10);
      chk("wfull errors", n_err, 1);
      chk("wfull writes", wr_q.size(), IMG);
      chk("wfull img_ready", img_ready, 0);
      chk("wfull busy", busy, 0);
      bf_block = 1'b0;
      tick(2);
   endtask

   task automatic test_cmd_as_payload();
      fill_random();
      payload[0] = 8'hA5;
      payload[1] = 8'h5A;
      run_full_image("cmd_payload");
   endtask

   task automatic test_reset_mid_image();
      int bad, c0;
      fill_random();
      mon_clear();
      send_payload(61);
      c0 = n_clr;
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if ({clear_buffer, data_out, write_request, img_ready, busy, error} !== 13'd0) bad++;
      end
      chk("midrst outputs_nonzero_cycles", bad, 0);
      chk("midrst clears_during_rst", n_clr - c0, 0);
      chk("midrst writes", wr_q.size(), 61);
      rst = 1'b0;
      tick(2);
      fill_random();
      run_full_image("after_rst");
   endtask

   initial begin
      test_reset();
      test_counting_image();
      test_clear_cmd();
      test_timeout();
      test_overflow();
      test_bad_cmd();
      test_cmd_as_payload();
      test_rx_in_ready();
      test_back_to_back();
      test_wait_full_timeout();
      test_reset_mid_image();
      chk("write_and_clear_overlap", both_hi, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/image_loader_ctrl.md
IMAGE_LOADER_CTRL -- requirements
Module: image_loader_ctrl

Interface
REQ-001 SHALL have parameter IMG_BYTES, default 113, meaning number of payload bytes per 30x30 image (904 bits, zero-padded).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning the maximum idle gap between payload bytes before abort.
REQ-003 SHALL have parameter CMD_LOAD, default 8'hA5, meaning the start-image command byte.
REQ-004 SHALL have parameter CMD_CLEAR, default 8'h5A, meaning the clear-only command byte.
REQ-005 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning the asynchronous, active-high reset.
REQ-007 SHALL have port rx_data, input, 8, meaning the received byte from the serial front end.
REQ-008 SHALL have port rx_valid, input, 1, meaning a one-cycle strobe that qualifies rx_data.
REQ-009 SHALL have port write_ready, input, 1, meaning the downstream image store can accept a byte.
REQ-010 SHALL have port buffer_full, input, 1, meaning the downstream image store holds IMG_BYTES bytes (one-cycle lag after the last write).
REQ-011 SHALL have port inference_done, input, 1, meaning a one-cycle strobe from the classifier that it has consumed the image.
REQ-012 SHALL have port clear_buffer, output, 1, meaning a one-cycle store-reset pulse.
REQ-013 SHALL have port data_out, output, 8, meaning the registered payload byte presented to the store.
REQ-014 SHALL have port write_request, output, 1, meaning a one-cycle write strobe qualifying data_out.
REQ-015 SHALL have port img_ready, output, 1, meaning a complete image is available to the classifier.
REQ-016 SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-017 SHALL have port error, output, 1, meaning a one-cycle pulse on any protocol fault.

Function
REQ-018 SHALL implement the FSM states IDLE, CLEAR, RECV, WAIT_FULL and READY.
REQ-019 IDLE: rx_valid with CMD_LOAD SHALL go to CLEAR; rx_valid with CMD_CLEAR SHALL pulse clear_buffer and stay in IDLE; any other byte SHALL pulse error and be dropped.
REQ-020 CLEAR SHALL assert clear_buffer for exactly one cycle, zero byte_cnt (7-bit) and the timeout counter, then go to RECV.
REQ-021 RECV: on rx_valid with write_ready high, the next cycle SHALL present data_out=rx_data with write_request high for one cycle, and byte_cnt SHALL increment (one-cycle latency).
REQ-022 RECV: rx_valid with write_ready low SHALL pulse error, drop the byte, and send the FSM to IDLE (overflow).
REQ-023 RECV: when the write of byte IMG_BYTES-1 is issued (byte_cnt reaches IMG_BYTES), the FSM SHALL go to WAIT_FULL.
REQ-024 WAIT_FULL SHALL go to READY when buffer_full is high; if buffer_full is not high within 4 cycles, it SHALL pulse error and go to IDLE.
REQ-025 READY SHALL hold img_ready high until inference_done, then go to IDLE; rx_valid in READY SHALL pulse error and be ignored.
REQ-026 In RECV, the timeout counter SHALL reset on each rx_valid and otherwise increment; at TIMEOUT_CYCLES-1 it SHALL pulse error and go to IDLE.
REQ-027 If rx_valid and timeout expiry occur in the same cycle, the byte SHALL win and the counter SHALL reset.
REQ-028 CMD_LOAD or CMD_CLEAR values arriving in RECV SHALL be treated as payload data.
REQ-029 write_request and clear_buffer SHALL never be high in the same cycle.

Reset
REQ-030 While rst is high, the state SHALL be IDLE, byte_cnt 0, timeout counter 0, and every output 0 (data_out 8'h00).
REQ-031 Reset mid-image SHALL abandon the image without asserting clear_buffer; the next CMD_LOAD performs the clear.

Structure
REQ-032 A shared package bnn_ocr_pkg SHALL hold the loader_state_t enum, IMG_BYTES, CMD_LOAD and CMD_CLEAR.
REQ-033 The timeout counter SHALL be one sub-module, idle_timer (parameter TIMEOUT_CYCLES; inputs clr and en; output expired).

Verification
REQ-034 Send A5 followed by 113 bytes 00..70 -> one clear_buffer pulse, 113 write_request pulses with data_out 00..70 in order, img_ready after buffer_full, and img_ready low one cycle after inference_done.
REQ-035 Send 5A in IDLE -> one clear_buffer pulse, busy stays 0, no write_request.
REQ-036 Send A5 and 50 bytes, then idle TIMEOUT_CYCLES (bench value 100) -> one error pulse, state IDLE, img_ready 0.
REQ-037 Send A5 and 10 bytes, force write_ready=0, send 1 byte -> one error pulse, that byte not written, busy falls.
REQ-038 Send byte 3C in IDLE -> one error pulse and no other output activity; send A5 then A5 as payload byte 0 -> data_out=A5 is written.
REQ-039 Assert rst after byte 60 of an image -> all outputs 0 while rst is high; a following A5 plus 113 bytes completes normally.
